// File: rtl/toggle_seq_ctrl.sv
// toggle_seq_ctrl: command-driven toggle controller turning a T-FF bank into a loadable up/down counter
// Define SATURATE_EN to hold the count at all-ones/all-zeros instead of wrapping.
module toggle_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             pause,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] t_out,
  output logic             busy,
  output logic             done,
  output logic             wrap
);
  typedef enum logic [1:0] {IDLE, EXEC, RUN, DONE} state_t;
  localparam logic [1:0] OP_LD = 2'b01;
  localparam logic [1:0] OP_DN = 2'b11;
  state_t state, state_nx;
  logic [1:0] op;
  logic [WIDTH-1:0] arg, cnt, cnt_nx, t_up, t_dn, t_cnt;
  logic step, edge_hit;
  assign t_up[0] = 1'b1;
  assign t_dn[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_carry
    assign t_up[i] = &q_in[i-1:0];
    assign t_dn[i] = ~|q_in[i-1:0];
  end
  assign edge_hit  = (op == OP_DN) ? ~|q_in : &q_in;
  assign step      = (state == RUN) && !pause;
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
`ifdef SATURATE_EN
  assign t_cnt = edge_hit ? '0 : ((op == OP_DN) ? t_dn : t_up);
`else
  assign t_cnt = (op == OP_DN) ? t_dn : t_up;
`endif
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    t_out    = '0;
    case (state)
      IDLE: if (cmd_valid) begin
        state_nx = cmd_op[1] ? ((|cmd_arg) ? RUN : DONE) : EXEC;
        cnt_nx   = cmd_arg;
      end
      EXEC: begin
        t_out    = (op == OP_LD) ? (q_in ^ arg) : q_in;
        state_nx = DONE;
      end
      RUN: if (!pause) begin
        t_out    = t_cnt;
        cnt_nx   = cnt - WIDTH'(1);
        state_nx = (cnt == WIDTH'(1)) ? DONE : RUN;
      end
      DONE: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op    <= '0;
      arg   <= '0;
      cnt   <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      wrap  <= step && edge_hit;
      if (cmd_valid && cmd_ready) begin
        op  <= cmd_op;
        arg <= cmd_arg;
      end
    end
  end
endmodule

// File: tb/tb_toggle_seq_ctrl.sv
// tb_toggle_seq_ctrl: drives toggle_seq_ctrl against a modelled T-FF bank with a per-cycle scoreboard
module tb_toggle_seq_ctrl;
  localparam int W = 8;
  localparam logic [1:0] CLR = 2'b00, LD = 2'b01, UP = 2'b10, DN = 2'b11;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, pause = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [W-1:0] cmd_arg = '0, q_bank, t_out, qm = '0;
  logic cmd_ready, busy, done, wrap;
  int tests = 0, fails = 0;
  typedef struct {
    logic v; logic [1:0] op; logic [W-1:0] arg; logic p;
    logic [W-1:0] q, t; logic dn, wr, bz, rd;
  } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  always @(posedge clk or posedge rst)
    if (rst) q_bank <= '0;
    else q_bank <= q_bank ^ t_out;
  toggle_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .pause(pause), .q_in(q_bank),
    .t_out(t_out), .busy(busy), .done(done), .wrap(wrap)
  );
  task automatic push(input logic v, input logic [1:0] op, input logic [W-1:0] arg, input logic p,
                      input logic [W-1:0] q, input logic [W-1:0] t,
                      input logic dn, input logic wr, input logic bz, input logic rd);
    exp_t e;
    e.v = v; e.op = op; e.arg = arg; e.p = p; e.q = q; e.t = t;
    e.dn = dn; e.wr = wr; e.bz = bz; e.rd = rd;
    sb.push_back(e);
  endtask
  // Expected per-cycle behaviour comes from plain arithmetic on the bank value, not toggle decoding.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] arg, input logic [31:0] pm,
                       input logic hold, input logic [1:0] nop, input logic [W-1:0] narg);
    logic [W-1:0] nq;
    logic w, p;
    int k, c;
    push(1'b1, op, arg, 1'b0, qm, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    w = 1'b0;
    if (!op[1]) begin
      nq = op[0] ? arg : '0;
      push(1'b0, 2'b00, '0, 1'b0, qm, qm ^ nq, 1'b0, 1'b0, 1'b1, 1'b0);
      qm = nq;
    end else begin
      k = 0;
      c = 0;
      while (k < int'(arg)) begin
        p = (c < 32) ? pm[c] : 1'b0;
        nq = op[0] ? qm - 8'd1 : qm + 8'd1;
        push(1'b0, 2'b00, '0, p, qm, p ? '0 : (qm ^ nq), 1'b0, w, 1'b1, 1'b0);
        if (!p) begin
          w = op[0] ? (qm == '0) : (qm == '1);
          qm = nq;
          k++;
        end else w = 1'b0;
        c++;
      end
    end
    push(hold, hold ? nop : 2'b00, hold ? narg : '0, 1'b0, qm, '0, 1'b1, w, 1'b1, 1'b0);
    if (!hold) push(1'b0, 2'b00, '0, 1'b0, qm, '0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic drain(input string name);
    exp_t e;
    int cyc;
    cyc = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cmd_valid = e.v; cmd_op = e.op; cmd_arg = e.arg; pause = e.p;
      #1;
      tests++;
      if ({q_bank, t_out, done, wrap, busy, cmd_ready} !== {e.q, e.t, e.dn, e.wr, e.bz, e.rd}) begin
        fails++;
        $display("FAIL %s cyc%0d: got q=%h t=%h done=%b wrap=%b busy=%b rdy=%b, want q=%h t=%h done=%b wrap=%b busy=%b rdy=%b",
                 name, cyc, q_bank, t_out, done, wrap, busy, cmd_ready, e.q, e.t, e.dn, e.wr, e.bz, e.rd);
      end
      cyc++;
      @(posedge clk);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    pause = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    qm = '0;
    repeat (2) begin
      #1;
      tests++;
      if ({q_bank, t_out, done, wrap, busy, cmd_ready} !== {8'h00, 8'h00, 4'b0001}) begin
        fails++;
        $display("FAIL reset: got q=%h t=%h done=%b wrap=%b busy=%b rdy=%b, want 00 00 0 0 0 1",
                 q_bank, t_out, done, wrap, busy, cmd_ready);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_load;
    issue(LD, 8'hA5, 0, 1'b0, CLR, '0);
    drain("load");
  endtask
  task automatic test_count_up_wrap;
    issue(LD, 8'hFD, 0, 1'b0, CLR, '0);
    issue(UP, 8'd4, 0, 1'b0, CLR, '0);
    drain("count_up_wrap");
  endtask
  task automatic test_count_down_pause;
    issue(LD, 8'h02, 0, 1'b0, CLR, '0);
    issue(DN, 8'd3, 32'b10, 1'b0, CLR, '0);
    drain("count_down_pause");
  endtask
  task automatic test_back_to_back;
    issue(UP, 8'd0, 0, 1'b1, LD, 8'h3C);
    issue(LD, 8'h3C, 0, 1'b1, DN, 8'd2);
    issue(DN, 8'd2, 0, 1'b0, CLR, '0);
    drain("back_to_back");
  endtask
  task automatic test_random;
    logic [1:0] op;
    logic [W-1:0] arg;
    for (int n = 0; n < 6; n++) begin
      op = 2'($urandom_range(0, 3));
      arg = op[1] ? W'($urandom_range(0, 12)) : W'($urandom);
      issue(op, arg, $urandom & 32'h0000_0555, 1'b0, CLR, '0);
    end
    drain("random");
  endtask
  task automatic test_reset_mid;
    cmd_valid = 1'b1; cmd_op = UP; cmd_arg = 8'd100;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    tests++;
    if ({q_bank, t_out[0], busy} !== {qm + 8'd3, 2'b11}) begin
      fails++;
      $display("FAIL reset_mid pre: got q=%h t0=%b busy=%b, want q=%h t0=1 busy=1", q_bank, t_out[0], busy, qm + 8'd3);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({q_bank, t_out, busy, done} !== {8'h00, 8'h00, 2'b00}) begin
      fails++;
      $display("FAIL reset_mid: got q=%h t=%h busy=%b done=%b, want 00 00 0 0", q_bank, t_out, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    qm = '0;
    #1;
    tests++;
    if ({done, wrap, busy, cmd_ready} !== 4'b0001) begin
      fails++;
      $display("FAIL reset_mid post: got done=%b wrap=%b busy=%b rdy=%b, want 0 0 0 1", done, wrap, busy, cmd_ready);
    end
    @(negedge clk);
    issue(LD, 8'h77, 0, 1'b0, CLR, '0);
    issue(CLR, '0, 0, 1'b0, CLR, '0);
    drain("reset_mid_clear");
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_load;
    test_count_up_wrap;
    test_count_down_pause;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
